// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - shared FSM state type and default widths for the SRAM arbiter
package sram_arbiter_pkg;

  localparam int DEF_DATA_WIDTH = 3;
  localparam int DEF_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_READ    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant with a last-grant register
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       update,
  output logic [1:0] grant
);

  // Index of the requester granted most recently; reset to 1 so requester 0 wins the first tie.
  logic last_grant;

  // A lone requester wins outright; on a tie the requester not served last wins.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Remember the winner only when its request is actually accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (update) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-requester arbiter driving an asynchronous single-port SRAM
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              rsp_rvalid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_wdone,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  output logic                    sram_csb,
  output logic                    sram_web,
  output logic                    sram_oeb,
  output logic [DATA_WIDTH-1:0]   sram_wdata,
  output logic                    sram_wdata_en,
  input  logic [DATA_WIDTH-1:0]   sram_rdata
);

  state_t                  state;
  logic [1:0]              grant;
  logic [1:0]              owner;
  logic                    fire;
  logic                    win;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  (req_valid),
    .update (fire),
    .grant  (grant)
  );

  // Ready is offered only in IDLE, only to the winner, and never while reset is held.
  always_comb begin
    req_ready = 2'b00;
    if (state == ST_IDLE && rst_n) begin
      req_ready = grant;
    end
  end

  assign fire      = |req_ready;
  assign win       = grant[1];
  assign sel_we    = win ? req_we[1] : req_we[0];
  assign sel_addr  = win ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
  assign sel_wdata = win ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];

  // Operation sequencer: every SRAM control and response is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      owner         <= 2'b00;
      sram_addr     <= '0;
      sram_wdata    <= '0;
      sram_csb      <= 1'b1;
      sram_web      <= 1'b1;
      sram_oeb      <= 1'b1;
      sram_wdata_en <= 1'b0;
      rsp_rvalid    <= 2'b00;
      rsp_wdone     <= 2'b00;
      rsp_rdata     <= '0;
    end else begin
      rsp_rvalid <= 2'b00;
      rsp_wdone  <= 2'b00;
      case (state)
        ST_IDLE: begin
          if (fire) begin
            owner     <= grant;
            sram_addr <= sel_addr;
            sram_csb  <= 1'b0;
            if (sel_we) begin
              state         <= ST_WRITE;
              sram_web      <= 1'b0;
              sram_oeb      <= 1'b1;
              sram_wdata_en <= 1'b1;
              sram_wdata    <= sel_wdata;
            end else begin
              state         <= ST_READ;
              sram_web      <= 1'b1;
              sram_oeb      <= 1'b0;
              sram_wdata_en <= 1'b0;
            end
          end
        end
        ST_WRITE: begin
          // SRAM latches the word on this edge; release the bus and report completion.
          state         <= ST_IDLE;
          sram_csb      <= 1'b1;
          sram_web      <= 1'b1;
          sram_oeb      <= 1'b1;
          sram_wdata_en <= 1'b0;
          rsp_wdone     <= owner;
        end
        ST_READ: begin
          // Give the SRAM a full cycle of access time before sampling.
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          state      <= ST_IDLE;
          rsp_rdata  <= sram_rdata;
          rsp_rvalid <= owner;
          sram_csb   <= 1'b1;
          sram_oeb   <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
module tb_sram_arbiter;

  localparam int DW = 3;
  localparam int AW = 4;

  logic          clk;
  logic          rst_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [1:0]    req_we;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]    rsp_rvalid;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_wdone;
  logic [AW-1:0] sram_addr;
  logic          sram_csb;
  logic          sram_web;
  logic          sram_oeb;
  logic [DW-1:0] sram_wdata;
  logic          sram_wdata_en;
  logic [DW-1:0] sram_rdata;

  logic [DW-1:0] mem [16];

  int checks = 0;
  int errors = 0;

  sram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_rvalid    (rsp_rvalid),
    .rsp_rdata     (rsp_rdata),
    .rsp_wdone     (rsp_wdone),
    .sram_addr     (sram_addr),
    .sram_csb      (sram_csb),
    .sram_web      (sram_web),
    .sram_oeb      (sram_oeb),
    .sram_wdata    (sram_wdata),
    .sram_wdata_en (sram_wdata_en),
    .sram_rdata    (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous-read SRAM model, written on the rising edge.
  always @(posedge clk) begin
    if (!sram_csb && !sram_web) mem[sram_addr] <= sram_wdata;
  end
  assign sram_rdata = (!sram_csb && !sram_oeb) ? mem[sram_addr] : '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output enable and write drive must never overlap on the shared data bus.
  always @(negedge clk) begin
    if (rst_n) check("bus_contention", 32'(!sram_oeb && sram_wdata_en), 32'd0);
  end

  task automatic wait_ready(input int i, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (req_ready[i]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_write(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok;
    req_we[i] = 1'b1;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_valid[i] = 1'b1;
    wait_ready(i, ok);
    if (ok) begin
      @(posedge clk);
      #1 req_valid[i] = 1'b0;
      @(negedge clk);
      check("wr_csb", 32'(sram_csb), 32'd0);
      check("wr_web", 32'(sram_web), 32'd0);
      check("wr_oeb", 32'(sram_oeb), 32'd1);
      check("wr_en", 32'(sram_wdata_en), 32'd1);
      check("wr_addr", 32'(sram_addr), 32'(a));
      check("wr_data", 32'(sram_wdata), 32'(d));
      check("wr_done_early", 32'(rsp_wdone), 32'd0);
      @(negedge clk);
      check("wr_done", 32'(rsp_wdone), 32'(2'b01 << i));
      check("wr_idle_csb", 32'(sram_csb), 32'd1);
    end else begin
      req_valid[i] = 1'b0;
    end
  endtask

  task automatic do_read(input int i, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    bit ok;
    req_we[i] = 1'b0;
    req_addr[i*AW +: AW] = a;
    req_valid[i] = 1'b1;
    wait_ready(i, ok);
    if (ok) begin
      @(posedge clk);
      #1 req_valid[i] = 1'b0;
      @(negedge clk);
      check("rd_csb", 32'(sram_csb), 32'd0);
      check("rd_web", 32'(sram_web), 32'd1);
      check("rd_oeb", 32'(sram_oeb), 32'd0);
      check("rd_en", 32'(sram_wdata_en), 32'd0);
      check("rd_addr", 32'(sram_addr), 32'(a));
      @(negedge clk);
      check("rd_cap_oeb", 32'(sram_oeb), 32'd0);
      check("rd_valid_early", 32'(rsp_rvalid), 32'd0);
      @(negedge clk);
      check("rd_valid", 32'(rsp_rvalid), 32'(2'b01 << i));
      check("rd_data", 32'(rsp_rdata), 32'(exp));
    end else begin
      req_valid[i] = 1'b0;
    end
  endtask

  task automatic apply_reset();
    req_valid = 2'b00;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int n;
  int gidx [6];
  int gcyc [6];
  bit ok;

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b01;
    req_we    = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_csb", 32'(sram_csb), 32'd1);
    check("rst_web", 32'(sram_web), 32'd1);
    check("rst_oeb", 32'(sram_oeb), 32'd1);
    check("rst_en", 32'(sram_wdata_en), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rvalid", 32'(rsp_rvalid), 32'd0);
    check("rst_wdone", 32'(rsp_wdone), 32'd0);
    check("rst_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_wdata", 32'(sram_wdata), 32'd0);
    req_valid = 2'b00;
    rst_n = 1'b1;
    @(negedge clk);

    // Basic write then read-back on requester 0.
    do_write(0, 4'd4, 3'b101);
    do_read(0, 4'd4, 3'b101);
    @(negedge clk);
    check("rdata_hold", 32'(rsp_rdata), 32'd5);
    check("rvalid_pulse", 32'(rsp_rvalid), 32'd0);
    do_write(0, 4'd1, 3'b011);

    // Tie from reset: req0 read first, req1 write in the next IDLE.
    apply_reset();
    req_we    = 2'b10;
    req_addr  = {4'd2, 4'd1};
    req_wdata = {3'b110, 3'b000};
    req_valid = 2'b11;
    #1 check("tie_first", 32'(req_ready), 32'b01);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    check("ignore_read", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("ignore_cap", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("tie_rvalid", 32'(rsp_rvalid), 32'b01);
    check("tie_rdata", 32'(rsp_rdata), 32'd3);
    check("tie_second", 32'(req_ready), 32'b10);
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(negedge clk);
    check("tie_wr_addr", 32'(sram_addr), 32'd2);
    check("tie_wr_data", 32'(sram_wdata), 32'd6);
    @(negedge clk);
    check("tie_wdone", 32'(rsp_wdone), 32'b10);

    // Continuous contention: six write grants must alternate, two cycles apart.
    req_we    = 2'b11;
    req_addr  = {4'd6, 4'd5};
    req_wdata = {3'b010, 3'b001};
    req_valid = 2'b11;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (req_ready != 2'b00) begin
        gidx[n] = req_ready[1] ? 1 : 0;
        gcyc[n] = c;
        n++;
      end
      if (n == 6) break;
      @(negedge clk);
    end
    req_valid = 2'b00;
    check("rr_count", 32'(n), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < n) check("rr_order", 32'(gidx[k]), 32'(k % 2));
      if (k > 0 && k < n) check("rr_gap", 32'(gcyc[k] - gcyc[k-1]), 32'd2);
    end
    @(negedge clk);
    @(negedge clk);

    // Reset in the middle of a read from requester 1.
    apply_reset();
    req_we    = 2'b00;
    req_addr  = {4'd3, 4'd0};
    req_valid = 2'b10;
    wait_ready(1, ok);
    if (ok) begin
      @(posedge clk);
      #1 req_valid = 2'b00;
      @(negedge clk);
      check("mid_read_csb", 32'(sram_csb), 32'd0);
      #1 rst_n = 1'b0;
      #1;
      check("async_csb", 32'(sram_csb), 32'd1);
      check("async_oeb", 32'(sram_oeb), 32'd1);
      check("async_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
        check("abort_rvalid", 32'(rsp_rvalid), 32'd0);
        @(negedge clk);
      end
      req_we    = 2'b11;
      req_valid = 2'b11;
      #1 check("post_rst_grant", 32'(req_ready), 32'b01);
      req_valid = 2'b00;
      @(negedge clk);
    end else begin
      req_valid = 2'b00;
    end

    // Address extremes with data written and read back by both requesters.
    do_write(0, 4'd15, 3'b111);
    do_write(1, 4'd0, 3'b010);
    do_read(1, 4'd15, 3'b111);
    do_read(0, 4'd0, 3'b010);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 3, SRAM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, SRAM address width (16 words).
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  in  2  per-requester request valid, bit i = requester i.
REQ-006 SHALL have port req_ready  out  2  per-requester accept; transfer when valid & ready.
REQ-007 SHALL have port req_we  in  2  per-requester op: 1 = write, 0 = read.
REQ-008 SHALL have port req_addr  in  2*ADDR_WIDTH  per-requester address, slice i.
REQ-009 SHALL have port req_wdata  in  2*DATA_WIDTH  per-requester write data, slice i.
REQ-010 SHALL have port rsp_rvalid  out  2  one-cycle read-data-valid pulse per requester.
REQ-011 SHALL have port rsp_rdata  out  DATA_WIDTH  read data, valid when any rsp_rvalid bit set.
REQ-012 SHALL have port rsp_wdone  out  2  one-cycle write-complete pulse per requester.
REQ-013 SHALL have ports sram_addr out ADDR_WIDTH, sram_csb/sram_web/sram_oeb out 1 (active-low SRAM controls).
REQ-014 SHALL have ports sram_wdata out DATA_WIDTH, sram_wdata_en out 1 (tri-state enable for top-level DATA bus), sram_rdata in DATA_WIDTH.

Function
REQ-015 SHALL implement FSM IDLE, WRITE, READ, CAPTURE; all SRAM outputs registered.
REQ-016 SHALL assert req_ready only in IDLE, and only to the granted requester.
REQ-017 SHALL grant round-robin: single valid wins; both valid -> requester not granted last; last_grant resets so requester 0 wins first tie.
REQ-018 SHALL on write accept go IDLE->WRITE for one cycle driving csb=0, web=0, oeb=1, wdata_en=1, addr/wdata latched from winner.
REQ-019 SHALL pulse rsp_wdone[i] in the cycle after WRITE (SRAM sampled at end of WRITE), then return to IDLE.
REQ-020 SHALL on read accept go IDLE->READ->CAPTURE, driving csb=0, web=1, oeb=0, wdata_en=0 in both states.
REQ-021 SHALL register sram_rdata at end of CAPTURE and pulse rsp_rvalid[i] with rsp_rdata the next cycle (2 cycles after accept edge).
REQ-022 SHALL hold csb=web=oeb=1, wdata_en=0 in IDLE; wdata_en and oeb=0 never asserted together.
REQ-023 SHALL ignore req_valid outside IDLE; requesters hold valid/we/addr/wdata stable until ready.
REQ-024 SHALL re-enter arbitration in the cycle after WRITE/CAPTURE; back-to-back throughput 1 write per 2 cycles, 1 read per 3 cycles.
REQ-025 SHALL keep rsp_rdata unchanged except on a read capture.

Reset
REQ-026 SHALL on rst_n=0 immediately force IDLE, csb=web=oeb=1, wdata_en=0, req_ready=0, rsp_rvalid=0, rsp_wdone=0, rsp_rdata=0, sram_addr=0, sram_wdata=0, last_grant=1.
REQ-027 SHALL abort any in-flight op on mid-operation reset with no rsp pulse emitted afterwards.

Structure
REQ-028 SHALL place FSM state enum and default width constants in package sram_arbiter_pkg.
REQ-029 SHALL contain one sub-module rr_arbiter2 (2-way round-robin grant with last_grant register).

Verification
REQ-030 SHALL verify: req0 write addr=4 data=3'b101 -> wdone[0] 1 cycle after WRITE; req0 read addr=4 -> rvalid[0], rdata=3'b101 2 cycles after accept.
REQ-031 SHALL verify: both valid from reset (req0 read addr=1, req1 write addr=2) -> req0 granted first, req1 granted next IDLE.
REQ-032 SHALL verify: both valid continuously for 6 grants -> grants alternate 0,1,0,1,0,1.
REQ-033 SHALL verify: rst_n low during READ -> csb=1 same cycle (async), no rvalid, next grant to requester 0.
REQ-034 SHALL verify: write 3'b111 to addr=15 then read addr=15, and addr=0 -> wrap extremes, correct data, oeb and wdata_en never both active.
